// File: rtl/nn_class_decider.sv
// Argmax decider for the network's per-class score vector: scans one class per cycle,
// then applies a confidence threshold and a consecutive-frame agreement rule.
module nn_class_decider #(
    parameter int NUM_CLASSES = 10,
    parameter int PROB_W = 16,
    parameter logic signed [PROB_W-1:0] THRESHOLD = 16'sd8192,
    parameter int HOLD_FRAMES = 2,
    parameter int CLS_W = $clog2(NUM_CLASSES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     prob_valid,
    output logic                     prob_ready,
    input  logic signed [PROB_W-1:0] probabilities [0:NUM_CLASSES-1],
    input  logic                     flush,
    output logic [CLS_W-1:0]         class_id,
    output logic signed [PROB_W-1:0] class_score,
    output logic                     class_valid,
    output logic                     class_reject
);

    localparam int STREAK_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [STREAK_W-1:0] HOLD_MAX = STREAK_W'(HOLD_FRAMES);
    localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DECIDE} state_t;

    state_t state, state_next;

    logic signed [PROB_W-1:0] frame_buf [0:NUM_CLASSES-1];
    logic signed [PROB_W-1:0] best_score;
    logic [CLS_W-1:0]         best_idx;
    logic [CLS_W-1:0]         idx;
    logic [STREAK_W-1:0]      streak;
    logic [CLS_W-1:0]         last_winner;
    logic                     emitted;

    logic                     accept;
    logic                     confident;
    logic                     same_winner;
    logic [STREAK_W-1:0]      streak_new;
    logic                     emitted_base;
    logic                     fire;

    assign accept = (state == IDLE) && prob_valid && prob_ready && !flush;

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = SCAN;
                SCAN:    if (idx == LAST_IDX) state_next = DECIDE;
                DECIDE:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Agreement bookkeeping for the frame currently in DECIDE.
    always_comb begin
        confident    = (best_score >= THRESHOLD);
        same_winner  = (best_idx == last_winner) && (streak != '0);
        streak_new   = STREAK_W'(1);
        emitted_base = 1'b0;
        if (same_winner) begin
            streak_new   = (streak == HOLD_MAX) ? streak : streak + STREAK_W'(1);
            emitted_base = emitted;
        end
        fire = (streak_new == HOLD_MAX) && !emitted_base;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prob_ready <= 1'b1;
        end else begin
            state      <= state_next;
            prob_ready <= (state_next == IDLE);
        end
    end

    // The buffer is frozen outside the accept cycle, so input changes mid-scan are ignored.
    always_ff @(posedge clk) begin
        if (accept) frame_buf <= probabilities;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            best_score   <= '0;
            best_idx     <= '0;
            class_id     <= '0;
            class_score  <= '0;
            class_valid  <= 1'b0;
            class_reject <= 1'b0;
            streak       <= '0;
            last_winner  <= '0;
            emitted      <= 1'b0;
        end else begin
            class_valid  <= 1'b0;
            class_reject <= 1'b0;
            if (flush) begin
                streak      <= '0;
                last_winner <= '0;
                emitted     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            best_score <= probabilities[0];
                            best_idx   <= '0;
                            idx        <= CLS_W'(1);
                        end
                    end
                    SCAN: begin
                        if (frame_buf[idx] > best_score) begin
                            best_score <= frame_buf[idx];
                            best_idx   <= idx;
                        end
                        idx <= idx + CLS_W'(1);
                    end
                    DECIDE: begin
                        class_id    <= best_idx;
                        class_score <= best_score;
                        if (confident) begin
                            streak      <= streak_new;
                            last_winner <= best_idx;
                            emitted     <= emitted_base || fire;
                            class_valid <= fire;
                        end else begin
                            streak       <= '0;
                            emitted      <= 1'b0;
                            class_reject <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nn_class_decider.sv
// Directed bench for nn_class_decider: detection, ties, threshold, flush, throughput, async reset.
module tb_nn_class_decider;

    localparam int NUM_CLASSES = 10;
    localparam int PROB_W = 16;
    localparam int CLS_W = $clog2(NUM_CLASSES);

    logic                     clk;
    logic                     rst_n;
    logic                     prob_valid;
    logic                     flush;
    logic signed [PROB_W-1:0] probabilities [0:NUM_CLASSES-1];

    logic                     prob_ready;
    logic [CLS_W-1:0]         class_id;
    logic signed [PROB_W-1:0] class_score;
    logic                     class_valid;
    logic                     class_reject;

    logic                     prob_ready1;
    logic [CLS_W-1:0]         class_id1;
    logic signed [PROB_W-1:0] class_score1;
    logic                     class_valid1;
    logic                     class_reject1;

    int checks = 0;
    int errors = 0;
    int v_cnt, r_cnt, v_at, r_at, both_cnt, v1_cnt;

    nn_class_decider #(.NUM_CLASSES(NUM_CLASSES), .PROB_W(PROB_W), .HOLD_FRAMES(2)) dut (
        .clk(clk), .rst_n(rst_n), .prob_valid(prob_valid), .prob_ready(prob_ready),
        .probabilities(probabilities), .flush(flush), .class_id(class_id),
        .class_score(class_score), .class_valid(class_valid), .class_reject(class_reject)
    );

    // Same inputs, single-frame agreement, to cover the HOLD_FRAMES=1 case.
    nn_class_decider #(.NUM_CLASSES(NUM_CLASSES), .PROB_W(PROB_W), .HOLD_FRAMES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .prob_valid(prob_valid), .prob_ready(prob_ready1),
        .probabilities(probabilities), .flush(flush), .class_id(class_id1),
        .class_score(class_score1), .class_valid(class_valid1), .class_reject(class_reject1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic fillFrame(input int base, input int ia, input int va, input int ib, input int vb);
        for (int i = 0; i < NUM_CLASSES; i++) probabilities[i] = PROB_W'(base);
        probabilities[ia] = PROB_W'(va);
        probabilities[ib] = PROB_W'(vb);
    endtask

    // Hands over the current vector, scrambles the inputs, and records pulses for 11 cycles.
    task automatic applyStimulus();
        int waited;
        waited = 0;
        v_cnt = 0; r_cnt = 0; v_at = -1; r_at = -1; both_cnt = 0; v1_cnt = 0;
        @(negedge clk);
        prob_valid = 1'b1;
        while (!prob_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!prob_ready) begin
            checkOutput("ready_timeout", 0, 1);
            prob_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        prob_valid = 1'b0;
        for (int i = 0; i < NUM_CLASSES; i++) probabilities[i] = 16'sd32000;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
            if (class_valid) begin v_cnt++; v_at = k; end
            if (class_reject) begin r_cnt++; r_at = k; end
            if (class_valid && class_reject) both_cnt++;
            if (class_valid1) v1_cnt++;
        end
    endtask

    initial begin
        int pulses;
        int acc_n;
        int acc_c [0:9];

        rst_n = 1'b0;
        prob_valid = 1'b0;
        flush = 1'b0;
        fillFrame(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        checkOutput("rst_ready", prob_ready, 1);
        checkOutput("rst_class_id", class_id, 0);
        checkOutput("rst_score", class_score, 0);
        checkOutput("rst_valid", class_valid, 0);
        checkOutput("rst_reject", class_reject, 0);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (class_valid || class_reject) pulses++;
        end
        checkOutput("idle_pulses", pulses, 0);

        fillFrame(100, 3, 20000, 3, 20000);
        applyStimulus();
        checkOutput("det1_valid", v_cnt, 0);
        checkOutput("det1_reject", r_cnt, 0);
        checkOutput("det1_class_id", class_id, 3);
        fillFrame(100, 3, 20000, 3, 20000);
        applyStimulus();
        checkOutput("det2_valid", v_cnt, 1);
        checkOutput("det2_latency", v_at, 10);
        checkOutput("det2_class_id", class_id, 3);
        checkOutput("det2_score", class_score, 20000);
        checkOutput("det2_both", both_cnt, 0);
        fillFrame(100, 3, 20000, 3, 20000);
        applyStimulus();
        checkOutput("det3_valid", v_cnt, 0);
        checkOutput("det3_reject", r_cnt, 0);

        fillFrame(0, 0, 8191, 0, 8191);
        applyStimulus();
        checkOutput("thr_reject", r_cnt, 1);
        checkOutput("thr_reject_at", r_at, 10);
        checkOutput("thr_valid", v_cnt, 0);
        checkOutput("thr_score", class_score, 8191);
        fillFrame(0, 5, 9000, 5, 9000);
        applyStimulus();
        checkOutput("win5_valid", v_cnt, 0);
        checkOutput("win5_class_id", class_id, 5);
        fillFrame(0, 6, 9000, 6, 9000);
        applyStimulus();
        checkOutput("win6_valid", v_cnt, 0);
        checkOutput("win6_reject", r_cnt, 0);
        checkOutput("win6_class_id", class_id, 6);

        // Flush mid-scan: a following class-6 frame would otherwise complete the streak.
        fillFrame(0, 6, 9000, 6, 9000);
        @(negedge clk);
        prob_valid = 1'b1;
        @(posedge clk);
        #1;
        prob_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_ready", prob_ready, 1);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (class_valid || class_reject) pulses++;
        end
        checkOutput("flush_pulses", pulses, 0);
        checkOutput("flush_class_id_held", class_id, 6);
        fillFrame(0, 6, 9000, 6, 9000);
        applyStimulus();
        checkOutput("post_flush_valid", v_cnt, 0);

        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        fillFrame(-500, 2, 9000, 7, 9000);
        applyStimulus();
        checkOutput("tie_class_id", class_id, 2);
        checkOutput("tie_score", class_score, 9000);
        checkOutput("tie_valid", v_cnt, 0);
        checkOutput("tie_hold1_valid", v1_cnt, 1);
        checkOutput("tie_hold1_class_id", class_id1, 2);
        fillFrame(-500, 2, 9000, 7, 9000);
        applyStimulus();
        checkOutput("tie2_valid", v_cnt, 1);
        checkOutput("tie2_hold1_valid", v1_cnt, 0);

        fillFrame(0, 1, 10000, 1, 10000);
        acc_n = 0;
        prob_valid = 1'b1;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (prob_ready && acc_n < 10) begin
                acc_c[acc_n] = c;
                acc_n++;
            end
        end
        @(posedge clk);
        #1;
        prob_valid = 1'b0;
        checkOutput("b2b_accepts", acc_n, 5);
        for (int i = 1; i < acc_n && i < 10; i++)
            checkOutput("b2b_interval", acc_c[i] - acc_c[i-1], 11);
        checkOutput("b2b_class_id", class_id, 1);

        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_ready", prob_ready, 1);
        checkOutput("async_class_id", class_id, 0);
        checkOutput("async_score", class_score, 0);
        checkOutput("async_valid", class_valid, 0);
        checkOutput("async_reject", class_reject, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nn_class_decider.md
Name: nn_class_decider

Overview:
- Sits directly downstream of the neural-network top and consumes its per-class output probability vector.
- Captures one frame of scores and scans them sequentially, one class per cycle, to find the argmax.
- Applies a confidence threshold and a consecutive-frame agreement rule.
- Emits a one-cycle recognised-word pulse, or a reject pulse, to the control/display logic.

Parameters:
- NUM_CLASSES, 10: number of classes (length of the probability vector). Must be ≥ 2.
- PROB_W, 16: width of each signed score.
- THRESHOLD, 16'sd8192: minimum winning score (signed compare, ≥) for a frame to count as confident.
- HOLD_FRAMES, 2: consecutive confident frames with the same winner needed to declare a detection. Must be ≥ 1.
- CLS_W, $clog2(NUM_CLASSES): class index width (derived).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- prob_valid  in  1  probability vector valid
- prob_ready  out  1  block can accept a vector
- probabilities  in  NUM_CLASSES x PROB_W signed, unpacked [0:NUM_CLASSES-1]  class scores from the network
- flush  in  1  synchronous clear of scan and agreement history
- class_id  out  CLS_W  winning class of the last decided frame
- class_score  out  PROB_W signed  winning score of the last decided frame
- class_valid  out  1  one-cycle detection pulse
- class_reject  out  1  one-cycle low-confidence pulse

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (rst_n). All state is registered on the rising edge of clk.
- Reset values: state=IDLE, prob_ready=1, class_id=0, class_score=0, class_valid=0, class_reject=0, streak=0, last_winner=0, emitted=0.
- FSM states: IDLE, SCAN, DECIDE.
- IDLE:
  - prob_ready=1.
  - On prob_valid && prob_ready: register the full vector into a local frame buffer; best_score=probabilities[0], best_idx=0, idx=1; go to SCAN.
  - prob_ready is a registered function of state and is independent of prob_valid.
- SCAN:
  - prob_ready=0.
  - Each cycle compare buf[idx] > best_score (signed, strict). On true, update best_score and best_idx.
  - Ties keep the lower index.
  - idx increments each cycle; after processing idx=NUM_CLASSES-1, go to DECIDE.
  - Input changes during SCAN are ignored because the buffer is frozen.
- DECIDE:
  - prob_ready=0. Register class_id=best_idx and class_score=best_score. Next state is IDLE.
  - If best_score ≥ THRESHOLD:
    - If best_idx==last_winner && streak>0: streak=min(streak+1, HOLD_FRAMES).
    - Otherwise: streak=1, last_winner=best_idx, emitted=0.
    - If the new streak==HOLD_FRAMES && !emitted: class_valid=1 for the next cycle, and emitted=1.
  - If best_score < THRESHOLD: streak=0, emitted=0, class_reject=1 for the next cycle.
  - A confident, already-emitted repeat frame produces neither pulse.
- Latency:
  - Handshake at edge E0; pulses and updated class_id/class_score are visible in the cycle after edge E(NUM_CLASSES).
  - Next accept is possible at edge E(NUM_CLASSES+1); throughput is one frame per NUM_CLASSES+1 cycles.
- Pulses: class_valid and class_reject are never high together and are high for exactly one cycle. class_id and class_score hold between frames.
- flush:
  - In any state, returns to IDLE next cycle, clears streak, last_winner and emitted, and drops any in-progress frame.
  - class_id and class_score keep their values. No pulse is generated.
  - flush together with prob_valid in IDLE: flush wins and the vector is not accepted.
- Reset mid-scan: immediately forces all reset values; the in-flight frame is lost.
- Arithmetic: all compares are signed PROB_W; there is no overflow path. The streak counter is $clog2(HOLD_FRAMES+1) bits wide and saturates.

Test Plan:
- Reset then idle: rst_n low for 3 cycles → prob_ready=1, class_id=0, class_valid=0, class_reject=0; no pulses for 20 cycles with prob_valid=0.
- Detection: two frames with class 3 = 20000 and all others = 100 → frame 1 gives no pulse; frame 2 gives class_valid=1 for one cycle with class_id=3, class_score=20000, at 10 cycles after the handshake. A third identical frame gives no pulse.
- Tie and negatives: scores all −500 except classes 2 and 7 = 9000 → class_id=2. With HOLD_FRAMES=1, class_valid pulses.
- Threshold and winner change:
  - Frame with max 8191 → class_reject pulse, streak cleared.
  - Then class 5 = 9000, then class 6 = 9000 → no class_valid, because the winner change resets the streak to 1.
- Flush and back-to-back:
  - Assert flush during cycle 4 of SCAN → IDLE next cycle, prob_ready=1, no pulse, and a subsequent single confident frame does not detect.
  - Hold prob_valid high continuously → accepts exactly every 11 cycles (NUM_CLASSES=10).
- Async reset mid-scan: drop rst_n between clock edges → outputs return to reset values immediately, before the next clock edge.
